// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
// Pipeline hazard controller: load-use stall, branch flush, operand/flag forwarding
// selects and saturating stall/flush event counters for a 5-stage core.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_Rn,
  input  logic [4:0]  id_Rm,
  input  logic [4:0]  id_Rd,
  input  logic        id_useRn,
  input  logic        id_useRm,
  input  logic        id_RegWrite,
  input  logic        id_memRead,
  input  logic        id_setFlag,
  input  logic        id_flagBr,
  input  logic        ex_BrTaken,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic        flagFwd,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       setflag;
  } stage_t;

  localparam logic [4:0] XZR = 5'd31;

  stage_t ex_p0, mem_p1, wb_p2;
  stage_t ex_nxt;
  logic   load_use;

  function automatic logic hit(input stage_t s, input logic [4:0] src);
    return s.vld && s.regwrite && (s.rd == src) && (src != XZR);
  endfunction

  // Youngest writer wins: EX, then MEM, then WB.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                         input stage_t ex, input stage_t mem,
                                         input stage_t wb);
    if (!used)         return 2'b00;
    if (hit(ex, src))  return 2'b01;
    if (hit(mem, src)) return 2'b10;
    if (hit(wb, src))  return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  always_comb begin
    load_use = id_valid && ex_p0.vld && ex_p0.memread &&
               ((id_useRn && hit(ex_p0, id_Rn)) || (id_useRm && hit(ex_p0, id_Rm)));
    flush    = ex_BrTaken;
    stall    = load_use && !ex_BrTaken;
    fwdA     = fwd_sel(id_useRn, id_Rn, ex_p0, mem_p1, wb_p2);
    fwdB     = fwd_sel(id_useRm, id_Rm, ex_p0, mem_p1, wb_p2);
    flagFwd  = id_valid && id_flagBr && ex_p0.vld && ex_p0.setflag;

    ex_nxt = '0;
    if (!stall && !flush && id_valid) begin
      ex_nxt.vld      = 1'b1;
      ex_nxt.rd       = id_Rd;
      ex_nxt.regwrite = id_RegWrite;
      ex_nxt.memread  = id_memRead;
      ex_nxt.setflag  = id_setFlag;
    end
  end

  // ID -> EX (p0) -> MEM (p1) -> WB (p2)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_p0     <= '0;
      mem_p1    <= '0;
      wb_p2     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_p0     <= ex_nxt;
      mem_p1    <= ex_p0;
      wb_p2     <= mem_p1;
      stall_cnt <= sat_inc(stall_cnt, stall);
      flush_cnt <= sat_inc(flush_cnt, flush);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
// Bench for hazard_ctrl: per-cycle model comparison plus directed literal checks.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_Rn = '0, id_Rm = '0, id_Rd = '0;
  logic        id_useRn = 1'b0, id_useRm = 1'b0;
  logic        id_RegWrite = 1'b0, id_memRead = 1'b0, id_setFlag = 1'b0, id_flagBr = 1'b0;
  logic        ex_BrTaken = 1'b0;
  logic        stall, flush, flagFwd;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
    .id_useRn(id_useRn), .id_useRm(id_useRm),
    .id_RegWrite(id_RegWrite), .id_memRead(id_memRead),
    .id_setFlag(id_setFlag), .id_flagBr(id_flagBr),
    .ex_BrTaken(ex_BrTaken),
    .stall(stall), .flush(flush), .fwdA(fwdA), .fwdB(fwdB),
    .flagFwd(flagFwd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the last three instructions that entered EX, youngest first.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
    bit sf;
  } rec_t;

  rec_t hist[3];
  int   tot_st = 0;
  int   tot_fl = 0;
  int   st_offset = 0;

  function automatic bit writes(input int k, input logic [4:0] src);
    return hist[k].v && hist[k].rw && (hist[k].rd == int'(src)) && (src != 5'd31);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic used, input logic [4:0] src);
    if (!used) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (writes(k, src)) return 2'(k + 1);
    return 2'b00;
  endfunction

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  initial begin : compare
    bit e_stall, e_flush, e_flag, lu;
    rec_t empty;
    empty = '{v: 0, rd: 0, rw: 0, mr: 0, sf: 0};
    for (int k = 0; k < 3; k++) hist[k] = empty;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int k = 0; k < 3; k++) hist[k] = empty;
        tot_st = 0;
        tot_fl = 0;
        chk("m_rst_stall", 16'(stall), 16'd0);
        chk("m_rst_flush", 16'(flush), 16'(ex_BrTaken));
        chk("m_rst_fwdA", 16'(fwdA), 16'd0);
        chk("m_rst_fwdB", 16'(fwdB), 16'd0);
        chk("m_rst_flagFwd", 16'(flagFwd), 16'd0);
        chk("m_rst_stall_cnt", stall_cnt, 16'd0);
        chk("m_rst_flush_cnt", flush_cnt, 16'd0);
      end else begin
        lu = id_valid && hist[0].v && hist[0].mr &&
             ((id_useRn && writes(0, id_Rn)) || (id_useRm && writes(0, id_Rm)));
        e_flush = ex_BrTaken;
        e_stall = lu && !e_flush;
        e_flag  = id_valid && id_flagBr && hist[0].v && hist[0].sf;
        chk("m_stall", 16'(stall), 16'(e_stall));
        chk("m_flush", 16'(flush), 16'(e_flush));
        chk("m_flagFwd", 16'(flagFwd), 16'(e_flag));
        if (!e_stall) begin
          chk("m_fwdA", 16'(fwdA), 16'(exp_fwd(id_useRn, id_Rn)));
          chk("m_fwdB", 16'(fwdB), 16'(exp_fwd(id_useRm, id_Rm)));
        end
        chk("m_stall_cnt", stall_cnt, sat16(tot_st + st_offset));
        chk("m_flush_cnt", flush_cnt, sat16(tot_fl));
        hist[2] = hist[1];
        hist[1] = hist[0];
        if (e_stall || e_flush || !id_valid) hist[0] = empty;
        else hist[0] = '{v: 1, rd: int'(id_Rd), rw: id_RegWrite, mr: id_memRead, sf: id_setFlag};
        if (e_stall) tot_st++;
        if (e_flush) tot_fl++;
      end
    end
  end

  // Drive one ID-stage cycle; returns just after the following falling edge.
  task automatic issue(input bit v, input int rn, input int rm, input int rd,
                       input bit urn, input bit urm, input bit rw, input bit mr,
                       input bit sf, input bit fb, input bit br);
    @(posedge clk);
    #1;
    id_valid = v; id_Rn = rn[4:0]; id_Rm = rm[4:0]; id_Rd = rd[4:0];
    id_useRn = urn; id_useRm = urm; id_RegWrite = rw; id_memRead = mr;
    id_setFlag = sf; id_flagBr = fb; ex_BrTaken = br;
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic ldur(input int rd);
    issue(1, 1, 0, rd, 1, 0, 1, 1, 0, 0, 0);
  endtask
  task automatic alu(input int rn, input int rm, input int rd, input bit urm, input bit sf);
    issue(1, rn, rm, rd, 1, urm, 1, 0, sf, 0, 0);
  endtask
  task automatic blt();
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_fwdA", 16'(fwdA), 16'd0);
    chk("rst_flagFwd", 16'(flagFwd), 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Load-use: one stall, then the load forwards from MEM.
    ldur(5);
    chk("lu_no_stall_first", 16'(stall), 16'd0);
    issue(1, 5, 2, 6, 1, 1, 1, 0, 1, 0, 0);
    chk("lu_stall", 16'(stall), 16'd1);
    chk("lu_cnt_before", stall_cnt, 16'd0);
    issue(1, 5, 2, 6, 1, 1, 1, 0, 1, 0, 0);
    chk("lu_stall_gone", 16'(stall), 16'd0);
    chk("lu_fwdA_mem", 16'(fwdA), 16'd2);
    chk("lu_cnt_after", stall_cnt, 16'd1);

    // Forward priority EX > MEM > WB.
    alu(1, 0, 3, 0, 0); alu(1, 0, 3, 0, 0); alu(1, 0, 3, 0, 0);
    alu(3, 3, 8, 1, 1);
    chk("pri_fwdA_ex", 16'(fwdA), 16'd1);
    chk("pri_fwdB_ex", 16'(fwdB), 16'd1);
    alu(1, 0, 3, 0, 0); alu(1, 0, 3, 0, 0); nop();
    alu(3, 3, 8, 1, 1);
    chk("pri_fwdA_mem", 16'(fwdA), 16'd2);
    chk("pri_fwdB_mem", 16'(fwdB), 16'd2);
    alu(1, 0, 3, 0, 0); nop(); nop();
    alu(3, 3, 8, 1, 1);
    chk("pri_fwdA_wb", 16'(fwdA), 16'd3);
    chk("pri_fwdB_wb", 16'(fwdB), 16'd3);

    // XZR never matches, even behind a load.
    ldur(31);
    alu(31, 0, 9, 0, 1);
    chk("xzr_fwdA", 16'(fwdA), 16'd0);
    chk("xzr_stall", 16'(stall), 16'd0);

    // Flag forwarding.
    alu(1, 2, 10, 1, 1);
    blt();
    chk("flag_fwd", 16'(flagFwd), 16'd1);
    alu(1, 2, 10, 1, 1);
    alu(1, 0, 11, 0, 0);
    blt();
    chk("flag_no_fwd", 16'(flagFwd), 16'd0);

    // Taken branch overrides a load-use stall and bubbles EX.
    ldur(5);
    issue(1, 5, 2, 6, 1, 1, 1, 0, 1, 0, 1);
    chk("br_flush", 16'(flush), 16'd1);
    chk("br_stall", 16'(stall), 16'd0);
    chk("br_flush_cnt_before", flush_cnt, 16'd0);
    issue(1, 5, 2, 6, 1, 1, 1, 0, 1, 0, 0);
    chk("br_ex_bubble_stall", 16'(stall), 16'd0);
    chk("br_ex_bubble_fwdA", 16'(fwdA), 16'd2);
    chk("br_flush_cnt_after", flush_cnt, 16'd1);

    // Saturation: preload the counter near its limit, then stall past it.
    st_offset = 32'hFFFA - tot_st;
    force dut.stall_cnt = 16'hFFFA;
    #1 release dut.stall_cnt;
    for (int i = 0; i < 8; i++) begin
      ldur(5);
      issue(1, 5, 0, 6, 1, 0, 1, 0, 0, 0, 0);
    end
    nop();
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);

    // Asynchronous reset in the middle of a stall.
    ldur(5);
    issue(1, 5, 0, 6, 1, 0, 1, 0, 0, 0, 0);
    chk("ar_stall_pre", 16'(stall), 16'd1);
    #1;
    st_offset = 0;
    reset = 1'b0;
    #1;
    chk("ar_stall", 16'(stall), 16'd0);
    chk("ar_flush", 16'(flush), 16'd0);
    chk("ar_fwdA", 16'(fwdA), 16'd0);
    chk("ar_fwdB", 16'(fwdB), 16'd0);
    chk("ar_flagFwd", 16'(flagFwd), 16'd0);
    chk("ar_stall_cnt", stall_cnt, 16'd0);
    chk("ar_flush_cnt", flush_cnt, 16'd0);
    id_valid = 1'b0; id_useRn = 1'b0; id_useRm = 1'b0; id_RegWrite = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    issue(1, 5, 0, 6, 1, 0, 1, 0, 0, 0, 0);
    chk("post_rst_stall", 16'(stall), 16'd0);
    chk("post_rst_fwdA", 16'(fwdA), 16'd0);
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning): none; all widths are fixed as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 id_valid  input  1  a decoded instruction is present in the ID stage.
REQ-005 id_Rn, id_Rm, id_Rd  input  5 each  source and destination register numbers of the ID instruction.
REQ-006 id_useRn, id_useRm  input  1 each  ID instruction reads Rn / Rm.
REQ-007 id_RegWrite, id_memRead, id_setFlag, id_flagBr  input  1 each  ID control bits; id_flagBr marks a B.cond that reads flags.
REQ-008 ex_BrTaken  input  1  a branch resolved taken in EX this cycle.
REQ-009 stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-010 flush  output  1  discard the IF/ID and ID/EX contents.
REQ-011 fwdA, fwdB  output  2 each  operand source for Rn / Rm: 00 register file, 01 EX result, 10 MEM result, 11 WB result.
REQ-012 flagFwd  output  1  the ID B.cond uses the flags being produced in EX instead of the flag register.
REQ-013 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-014 The block SHALL track three stage records (EX, MEM, WB). Each record holds valid, Rd, RegWrite, memRead and setFlag. All records advance on every rising clk edge.
REQ-015 When stall=0 and flush=0, EX SHALL load the ID fields qualified by id_valid. Otherwise EX SHALL load a bubble with all fields 0.
REQ-016 MEM SHALL load EX and WB SHALL load MEM unconditionally.
REQ-017 Register 31 (XZR) SHALL never match. A source equal to 5'd31 always yields fwd=00 and never causes a stall.
REQ-018 A source matches a stage when the stage is valid, RegWrite=1, and its Rd equals the source number.
REQ-019 For each used source, fwd SHALL select the youngest matching stage (EX over MEM over WB). If no stage matches, or the source is unused, fwd SHALL be 00.
REQ-020 stall SHALL be 1 when id_valid=1, EX is valid with memRead=1, and a used ID source matches EX's Rd (load-use). The stall lasts exactly 1 cycle, because the load then moves to MEM and forwards as 10.
REQ-021 While stall=1, fwdA and fwdB SHALL be don't-care. No bench check is made on them.
REQ-022 flagFwd SHALL be 1 when id_valid=1, id_flagBr=1, and EX is valid with setFlag=1; otherwise it is 0.
REQ-023 flush SHALL equal ex_BrTaken combinationally.
REQ-024 flush SHALL take priority over stall: when both conditions hold, the stall output is 0 and EX loads a bubble.
REQ-025 stall_cnt SHALL increment on each edge where stall=1, and flush_cnt on each edge where flush=1. Both saturate at 16'hFFFF and do not wrap.
REQ-026 All outputs SHALL be purely combinational from the stage records and the ID inputs, except the two counters, which are registered.

Reset
REQ-027 While reset=0, all stage records SHALL be cleared to 0 (invalid) and both counters cleared to 0, asynchronously.
REQ-028 While reset=0, stall, flush (given ex_BrTaken=0), fwdA, fwdB and flagFwd SHALL all read 0.
REQ-029 A reset asserted mid-stall SHALL drop stall to 0 immediately. After release, the next instruction issues with no hazard history.

Verification
REQ-030 Load-use: issue LDUR with Rd=X5, then ADDS with Rn=X5 -> stall=1 for 1 cycle and stall_cnt=1; the next cycle shows stall=0 and fwdA=10.
REQ-031 Forward priority: ADDI Rd=X3 three times in a row, then ADDS with Rn=X3 and Rm=X3 -> fwdA=fwdB=01; drop the 1st and 2nd writers and the result is 10, then 11.
REQ-032 XZR: ADDS Rd=X31, then SUBS with Rn=X31 -> fwdA=00 and stall=0.
REQ-033 Flags: SUBS (setFlag=1), then B.LT in ID -> flagFwd=1; with an intervening ADDI, flagFwd=0.
REQ-034 Branch overrides stall: hold the load-use condition and pulse ex_BrTaken=1 -> flush=1, stall=0, and EX becomes a bubble.
REQ-035 Counter saturation: force 65 540 stalls -> stall_cnt holds at 16'hFFFF.
REQ-036 Asynchronous reset: drive reset=0 between clk edges during a stall -> all outputs go to 0 before the next edge.
